du_reg_dump: RTL and testbench
==============================

DU_REG_DUMP -- requirements
Module: du_reg_dump

Interface
REQ-001 The module SHALL have parameter NUM_REGS, default 32, giving the number of registers dumped per sweep (legal range 1..32).
REQ-002 i_clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 i_reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 i_start  input  1  request to begin a register sweep, sampled only in IDLE.
REQ-005 o_du_reg_addr  output  5  registered read address driven into the register file debug port.
REQ-006 i_du_reg_data  input  32  combinational register file debug read data for o_du_reg_addr.
REQ-007 o_tx_data  output  8  byte offered to the downstream UART transmitter.
REQ-008 o_tx_valid  output  1  o_tx_data is valid.
REQ-009 i_tx_ready  input  1  transmitter accepts the byte this cycle.
REQ-010 o_busy  output  1  high in every state except IDLE.
REQ-011 o_done  output  1  one-cycle pulse after the last byte of a sweep is accepted.

Function
REQ-012 The FSM SHALL have the states IDLE, WAIT, SEND and DONE, with a 5-bit register index and a 2-bit byte counter.
REQ-013 IDLE: when i_start=1, the next state SHALL be WAIT, with index, o_du_reg_addr and byte counter set to 0; i_start=0 SHALL keep the FSM in IDLE.
REQ-014 WAIT lasts exactly one cycle, during which o_du_reg_addr is stable; at its end, i_du_reg_data SHALL be captured into a 32-bit shift register and the next state SHALL be SEND.
REQ-015 SEND: o_tx_valid SHALL be 1 and o_tx_data SHALL equal shift register bits [31:24].
REQ-016 A byte transfers only on a cycle with o_tx_valid=1 and i_tx_ready=1; o_tx_valid and o_tx_data SHALL be held unchanged until that cycle.
REQ-017 On each transfer with byte counter < 3, the shift register SHALL shift left by 8, the byte counter SHALL increment, and the FSM SHALL stay in SEND.
REQ-018 On a transfer with byte counter = 3 and index < NUM_REGS-1, the index and o_du_reg_addr SHALL increment, the byte counter SHALL clear, and the next state SHALL be WAIT.
REQ-019 On a transfer with byte counter = 3 and index = NUM_REGS-1, the next state SHALL be DONE.
REQ-020 DONE: o_done SHALL be 1 for exactly that one cycle, and the next state SHALL be IDLE.
REQ-021 Byte order SHALL be big-endian: bits [31:24], then [23:16], then [15:8], then [7:0], for registers in ascending order.
REQ-022 i_start SHALL be ignored in WAIT, SEND and DONE; a sweep SHALL never restart or truncate because of i_start.
REQ-023 o_tx_valid SHALL be 0 and o_tx_data SHALL be 8'h00 outside SEND.
REQ-024 An uninterrupted sweep with i_tx_ready held at 1 SHALL take 1 (IDLE exit) + NUM_REGS*5 + 1 (DONE) cycles from the i_start cycle to the return to IDLE.
REQ-025 The index SHALL never exceed NUM_REGS-1, and no address wrap-around SHALL occur.
REQ-026 o_du_reg_addr SHALL hold its last value in IDLE and DONE.

Reset
REQ-027 While i_reset=0, regardless of the clock, the FSM SHALL be IDLE, and o_du_reg_addr, index, byte counter, shift register, o_tx_data, o_tx_valid, o_busy and o_done SHALL all be 0.
REQ-028 Reset asserted mid-sweep SHALL abort it immediately, with o_tx_valid going to 0 without waiting for a handshake.
REQ-029 After i_reset returns to 1, the first sweep SHALL start only on a new i_start.

Verification
REQ-030 Basic dump: with NUM_REGS=32, reg k = 32'h0000_0100*k+k, and i_tx_ready=1, pulse i_start -> 128 bytes, starting 00,00,00,00, 00,00,01,01, and ending 00,00,1F,1F; o_done pulses once; 162 cycles from the i_start cycle to IDLE.
REQ-031 Backpressure: with reg 0 = 32'hDEADBEEF and i_tx_ready low for 3 cycles before each byte -> o_tx_data holds DE, AD, BE, EF in turn, each stable while stalled; no byte is lost or duplicated.
REQ-032 Start ignored: pulse i_start again during SEND of reg 5 -> the sweep continues unchanged and exactly one o_done occurs.
REQ-033 Reset mid-sweep: drive i_reset=0 during SEND of reg 10, byte 2 -> o_tx_valid, o_busy and o_du_reg_addr go to 0 asynchronously; after release with no i_start, o_tx_valid stays 0.
REQ-034 Small sweep: with NUM_REGS=1 and reg 0 = 32'h12345678 -> bytes 12, 34, 56, 78, then o_done, and o_du_reg_addr never exceeds 0.

Source files
------------

// File: rtl/du_reg_dump.sv
// Debug-unit register dump: sweeps the register file debug port and streams each
// 32-bit register out big-endian, one byte at a time, over a valid/ready handshake.
module du_reg_dump #(
    parameter int NUM_REGS = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    output logic [4:0]  o_du_reg_addr,
    input  logic [31:0] i_du_reg_data,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [1:0]  byte_q, byte_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        xfer_s;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        xfer_s  = tx_valid_q & i_tx_ready;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_WAIT;
                    idx_d   = 5'd0;
                    byte_d  = 2'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                shift_d = i_du_reg_data;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (xfer_s) begin
                    if (byte_q != 2'd3) begin
                        shift_d = {shift_q[23:0], 8'h00};
                        byte_d  = byte_q + 2'd1;
                    end else if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 5'd1;
                        byte_d  = 2'd0;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they are valid straight from flops
        tx_valid_d = (state_d == S_SEND);
        tx_data_d  = tx_valid_d ? shift_d[31:24] : 8'h00;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            idx_q      <= 5'd0;
            byte_q     <= 2'd0;
            shift_q    <= 32'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_du_reg_addr = idx_q;
    assign o_tx_data     = tx_data_q;
    assign o_tx_valid    = tx_valid_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_du_reg_dump.sv
// Self-checking bench for du_reg_dump: a 32-register instance and a 1-register instance,
// byte streams checked against scoreboards filled when each sweep is launched.
module tb_du_reg_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        start_b, rdy_b, txv_b, busy_b, done_b;
    logic [4:0]  addr_b;
    logic [31:0] data_b;
    logic [7:0]  txd_b;

    logic        start_s, rdy_s, txv_s, busy_s, done_s;
    logic [4:0]  addr_s;
    logic [31:0] data_s;
    logic [7:0]  txd_s;

    logic [31:0] rf [32];
    logic [31:0] r_s;

    assign data_b = rf[addr_b];
    assign data_s = (addr_s == 5'd0) ? r_s : 32'hBAD0_BAD0;

    du_reg_dump #(.NUM_REGS(32)) u_big (
        .i_clk(clk), .i_reset(rst_n), .i_start(start_b),
        .o_du_reg_addr(addr_b), .i_du_reg_data(data_b),
        .o_tx_data(txd_b), .o_tx_valid(txv_b), .i_tx_ready(rdy_b),
        .o_busy(busy_b), .o_done(done_b)
    );

    du_reg_dump #(.NUM_REGS(1)) u_small (
        .i_clk(clk), .i_reset(rst_n), .i_start(start_s),
        .o_du_reg_addr(addr_s), .i_du_reg_data(data_s),
        .o_tx_data(txd_s), .o_tx_valid(txv_s), .i_tx_ready(rdy_s),
        .o_busy(busy_s), .o_done(done_s)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] q_b [$];
    logic [7:0] q_s [$];
    int acc_b = 0;
    int done_b_cnt = 0;
    int done_s_cnt = 0;

    typedef struct {
        logic [31:0] data;
        int          stall;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_big_all();
        logic [31:0] v;
        for (int k = 0; k < 32; k++) begin
            v = 32'h0000_0100 * k + k;
            q_b.push_back(v[31:24]);
            q_b.push_back(v[23:16]);
            q_b.push_back(v[15:8]);
            q_b.push_back(v[7:0]);
        end
    endtask

    // Big-instance monitor: scoreboard pop on each handshake, done pulse count
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (done_b) done_b_cnt++;
            if (rst_n && txv_b && rdy_b) begin
                if (q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL big_extra_byte: got %h with empty scoreboard", txd_b);
                end else begin
                    e = q_b.pop_front();
                    chk("big_byte", 32'(txd_b), 32'(e));
                    acc_b++;
                end
            end
        end
    end

    // Small-instance monitor: scoreboard, hold-while-stalled, address bound
    initial begin
        logic [7:0] e;
        logic       pv = 1'b0;
        logic       pr = 1'b0;
        logic [7:0] pd = 8'h00;
        forever begin
            @(negedge clk);
            if (done_s) done_s_cnt++;
            if (rst_n) begin
                if (pv && !pr) begin
                    chk("small_hold_valid", 32'(txv_s), 32'd1);
                    chk("small_hold_data", 32'(txd_s), 32'(pd));
                end
                if (busy_s) chk("small_addr", 32'(addr_s), 32'd0);
                if (txv_s && rdy_s) begin
                    if (q_s.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL small_extra_byte: got %h with empty scoreboard", txd_s);
                    end else begin
                        e = q_s.pop_front();
                        chk("small_byte", 32'(txd_s), 32'(e));
                    end
                end
            end
            pv = txv_s;
            pr = rdy_s;
            pd = txd_s;
        end
    end

    task automatic run_big(input bit pulse_mid);
        int  cyc;
        int  d0;
        bit  pulsed;
        pulsed = 1'b0;
        push_big_all();
        d0 = done_b_cnt;
        rdy_b = 1'b1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        cyc = 1;
        while (busy_b && cyc < 400) begin
            if (pulse_mid && !pulsed && addr_b == 5'd5 && txv_b) begin
                start_b = 1'b1;
                pulsed = 1'b1;
            end else begin
                start_b = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_b = 1'b0;
        chk("big_sweep_cycles", 32'(cyc), 32'd162);
        chk("big_done_count", 32'(done_b_cnt - d0), 32'd1);
        chk("big_scoreboard_empty", 32'(q_b.size()), 32'd0);
        if (pulse_mid) chk("big_restart_pulse_issued", 32'(pulsed), 32'd1);
    endtask

    initial begin
        vec_t vt [5];
        int   n;
        int   d0;
        logic [7:0] bb [4];

        vt[0] = '{32'h1234_5678, 0, 8'h12, 8'h34, 8'h56, 8'h78};
        vt[1] = '{32'hDEAD_BEEF, 3, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        vt[2] = '{32'hFFFF_FFFF, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vt[3] = '{32'h0000_0000, 2, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[4] = '{32'hA5C3_0F81, 0, 8'hA5, 8'hC3, 8'h0F, 8'h81};

        rst_n = 1'b0;
        start_b = 1'b0; rdy_b = 1'b0;
        start_s = 1'b0; rdy_s = 1'b0;
        r_s = 32'd0;
        for (int k = 0; k < 32; k++) rf[k] = 32'h0000_0100 * k + k;

        #12;
        chk("rst_big_addr", 32'(addr_b), 32'd0);
        chk("rst_big_valid", 32'(txv_b), 32'd0);
        chk("rst_big_data", 32'(txd_b), 32'd0);
        chk("rst_big_busy", 32'(busy_b), 32'd0);
        chk("rst_big_done", 32'(done_b), 32'd0);
        chk("rst_small_valid", 32'(txv_s), 32'd0);
        chk("rst_small_busy", 32'(busy_s), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_start_busy", 32'(busy_b), 32'd0);

        // Full 32-register sweep, then again with a stray start in the middle
        run_big(1'b0);
        run_big(1'b1);

        // Single-register instance: table of words with per-byte ready stalls
        for (int i = 0; i < 5; i++) begin
            r_s = vt[i].data;
            bb[0] = vt[i].b0; bb[1] = vt[i].b1; bb[2] = vt[i].b2; bb[3] = vt[i].b3;
            for (int j = 0; j < 4; j++) q_s.push_back(bb[j]);
            d0 = done_s_cnt;
            start_s = 1'b1;
            @(posedge clk); #1;
            start_s = 1'b0;
            for (int j = 0; j < 4; j++) begin
                n = 0;
                while (!txv_s && n < 20) begin
                    @(posedge clk); #1;
                    n++;
                end
                if (n >= 20) begin
                    checks++;
                    errors++;
                    $display("FAIL small_valid_timeout: vector %0d byte %0d never offered", i, j);
                end
                repeat (vt[i].stall) begin
                    @(posedge clk); #1;
                end
                rdy_s = 1'b1;
                @(posedge clk); #1;
                rdy_s = 1'b0;
            end
            n = 0;
            while (busy_s && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            chk("small_done_count", 32'(done_s_cnt - d0), 32'd1);
            chk("small_scoreboard_empty", 32'(q_s.size()), 32'd0);
            chk("small_idle_busy", 32'(busy_s), 32'd0);
        end

        // Abort a sweep with reset during reg 10, byte 2
        push_big_all();
        d0 = done_b_cnt;
        acc_b = 0;
        rdy_b = 1'b1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        n = 0;
        while (acc_b != 42 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reached_point", 32'(acc_b), 32'd42);
        chk("abort_addr_before", 32'(addr_b), 32'd10);
        chk("abort_valid_before", 32'(txv_b), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(txv_b), 32'd0);
        chk("abort_busy", 32'(busy_b), 32'd0);
        chk("abort_addr", 32'(addr_b), 32'd0);
        chk("abort_data", 32'(txd_b), 32'd0);
        q_b.delete();
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("post_abort_valid", 32'(txv_b), 32'd0);
            chk("post_abort_busy", 32'(busy_b), 32'd0);
        end
        chk("abort_no_done", 32'(done_b_cnt - d0), 32'd0);
        rdy_b = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
